// File: rtl/tiny16_mem_arb.sv
// tiny16_mem_arb
//   Shares the single-ported synchronous tiny16 main memory between the CPU
//   port (port 0) and the loader/debug port (port 1). Each access runs
//   through IDLE -> ACC -> RESP -> IDLE, so one access completes every three
//   cycles. Ties are broken round-robin (FIXED_PRI=0) or in favour of
//   port 0 (FIXED_PRI=1). Every output is driven straight from a register.
//
// Handshake: a requester raises REQn with WEn/ADDRn/WDATAn stable and keeps
//   them stable until it sees ACKn, a single-cycle pulse. RDATAn is valid in
//   the ACK cycle and holds until the next read completes on that port. A
//   request is only eligible while its ACK is low, so a requester that still
//   shows REQ during its own ACK cycle is not served a second time.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   REQn/WEn/ADDRn/WDATAn   requester n access request (n = 0, 1)
//   ACKn/RDATAn         requester n completion pulse and read data
//   MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA   memory strobe, write enable, address, data
//   MEM_RDATA           memory read data, valid one edge after the MEM_EN edge
//   BUSY                high whenever the FSM is not in IDLE
//   GNT_ID              port currently or most recently granted
//   DBG_STATE           FSM state: 0 = IDLE, 1 = ACC, 2 = RESP
module tiny16_mem_arb #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int FIXED_PRI = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              ACK0,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA0,
  output logic [DATA_W-1:0] RDATA1,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY,
  output logic              GNT_ID,
  output logic [1:0]        DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last;      // port served by the most recent completed access
  logic   is_write;  // kept because MEM_WE is cleared before RESP

  logic elig0;
  logic elig1;
  logic any_elig;
  logic win;

  // The ACK mask stops a port from being re-granted on its own ACK edge.
  assign elig0    = REQ0 & ~ACK0;
  assign elig1    = REQ1 & ~ACK1;
  assign any_elig = elig0 | elig1;

  always_comb begin
    win = 1'b0;
    if (elig0 && elig1) begin
      if (FIXED_PRI != 0) win = 1'b0;
      else                win = ~last;
    end else if (elig1) begin
      win = 1'b1;
    end
  end

  assign DBG_STATE = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      last      <= 1'b1;  // port 0 wins the first tie
      is_write  <= 1'b0;
      ACK0      <= 1'b0;
      ACK1      <= 1'b0;
      RDATA0    <= '0;
      RDATA1    <= '0;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      BUSY      <= 1'b0;
      GNT_ID    <= 1'b0;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_elig) begin
            MEM_EN    <= 1'b1;
            MEM_WE    <= win ? WE1 : WE0;
            MEM_ADDR  <= win ? ADDR1 : ADDR0;
            MEM_WDATA <= win ? WDATA1 : WDATA0;
            is_write  <= win ? WE1 : WE0;
            GNT_ID    <= win;
            BUSY      <= 1'b1;
            state     <= ACC;
          end else begin
            MEM_EN <= 1'b0;
          end
        end
        ACC: begin
          // Memory captures the access on this edge; address and data hold.
          MEM_EN <= 1'b0;
          MEM_WE <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (GNT_ID) begin
            ACK1 <= 1'b1;
            if (!is_write) RDATA1 <= MEM_RDATA;
          end else begin
            ACK0 <= 1'b1;
            if (!is_write) RDATA0 <= MEM_RDATA;
          end
          last  <= GNT_ID;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          MEM_EN <= 1'b0;
          MEM_WE <= 1'b0;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny16_mem_arb.sv
// Testbench for tiny16_mem_arb. Two instances run side by side:
// instance 0 is round-robin, instance 1 is fixed priority. Each has its own
// synchronous memory model. Drivers push the expected response of every
// access into a per-port queue; a negedge monitor pops and compares on ACK.
module tb_tiny16_mem_arb;

  logic clk;
  logic rst;

  logic        req       [2][2];
  logic        we        [2][2];
  logic [7:0]  addr      [2][2];
  logic [15:0] wdata     [2][2];
  logic        ack       [2][2];
  logic [15:0] rdata     [2][2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [7:0]  mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic        busy      [2];
  logic        gnt       [2];
  logic [1:0]  dbg_state [2];

  // Expected responses, index d*2+p; bit 16 set means write (no data check).
  logic [16:0] exp_q [4][$];
  int          ack_port_log [2][$];
  int          ack_cyc_log  [2][$];
  logic [15:0] shadow [2][256];
  int          en_cnt [2];
  int          tx_cnt [2];
  logic        prev_en [2];
  int          cyc;
  int          checks;
  int          failures;

  function automatic logic [15:0] init_val(int i);
    return 16'(i * 257 + 32'h1234);
  endfunction

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs and memory models ----------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] mem [256];
    logic [15:0] rd;

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_val(i);
      rd = '0;
    end

    always @(posedge clk) begin
      if (mem_en[g]) begin
        if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
        else           rd <= mem[mem_addr[g]];
      end
    end

    tiny16_mem_arb #(.ADDR_W(8), .DATA_W(16), .FIXED_PRI(g)) dut (
      .CLK(clk), .RST(rst),
      .REQ0(req[g][0]), .REQ1(req[g][1]),
      .WE0(we[g][0]), .WE1(we[g][1]),
      .ADDR0(addr[g][0]), .ADDR1(addr[g][1]),
      .WDATA0(wdata[g][0]), .WDATA1(wdata[g][1]),
      .ACK0(ack[g][0]), .ACK1(ack[g][1]),
      .RDATA0(rdata[g][0]), .RDATA1(rdata[g][1]),
      .MEM_EN(mem_en[g]), .MEM_WE(mem_we[g]),
      .MEM_ADDR(mem_addr[g]), .MEM_WDATA(mem_wdata[g]),
      .MEM_RDATA(rd),
      .BUSY(busy[g]), .GNT_ID(gnt[g]), .DBG_STATE(dbg_state[g])
    );
  end

  // ---------------- checking helpers ----------------
  task automatic check_eq(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d] === 1'b1) begin
        en_cnt[d]++;
        check_eq("mem_en_one_cycle", 32'(prev_en[d]), 32'(0));
      end
      prev_en[d] = (mem_en[d] === 1'b1);
      if (ack[d][0] === 1'b1 || ack[d][1] === 1'b1)
        check_eq("ack_exclusive", 32'(ack[d][0] & ack[d][1]), 32'(0));
      for (int p = 0; p < 2; p++) begin
        if (ack[d][p] === 1'b1) begin
          ack_port_log[d].push_back(p);
          ack_cyc_log[d].push_back(cyc);
          if (exp_q[d*2+p].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: inst %0d port %0d got ack, expected none", d, p);
          end else begin
            logic [16:0] e;
            e = exp_q[d*2+p].pop_front();
            if (!e[16]) check_eq("read_data", 32'(rdata[d][p]), 32'(e[15:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Caller must be at a negedge. REQ stays high through the ACK cycle and is
  // dropped at the following negedge, like a registered requester.
  task automatic access(input int d, input int p, input logic w, input logic [7:0] a,
                        input logic [15:0] wd, input bit chk);
    int n;
    bit got;
    tx_cnt[d]++;
    if (w) begin
      shadow[d][a] = wd;
      exp_q[d*2+p].push_back({1'b1, wd});
    end else begin
      exp_q[d*2+p].push_back({1'b0, shadow[d][a]});
    end
    req[d][p] = 1'b1;
    we[d][p] = w;
    addr[d][p] = a;
    wdata[d][p] = wd;
    got = 0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (chk && n == 1) begin
        check_eq("grant_mem_en", 32'(mem_en[d]), 32'(1));
        check_eq("grant_mem_we", 32'(mem_we[d]), 32'(w));
        check_eq("grant_mem_addr", 32'(mem_addr[d]), 32'(a));
        check_eq("grant_gnt_id", 32'(gnt[d]), 32'(p));
        check_eq("grant_busy", 32'(busy[d]), 32'(1));
        if (w) check_eq("grant_mem_wdata", 32'(mem_wdata[d]), 32'(wd));
      end
      if (ack[d][p] === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: inst %0d port %0d no ack within %0d cycles", d, p, n);
    end else if (chk) begin
      check_eq("ack_latency", 32'(n), 32'(3));
    end
    @(negedge clk);
    req[d][p] = 1'b0;
  endtask

  task automatic rand_port(input int d, input int p, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      access(d, p, 1'($urandom_range(0, 1)), {7'($urandom_range(0, 127)), 1'(p)},
             16'($urandom), 0);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    failures = 0;
    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0;
      tx_cnt[d] = 0;
      prev_en[d] = 1'b0;
      for (int i = 0; i < 256; i++) shadow[d][i] = init_val(i);
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0;
        we[d][p] = 1'b0;
        addr[d][p] = '0;
        wdata[d][p] = '0;
      end
    end

    // Reset held for two cycles, then every output must be zero.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_ack0", 32'(ack[d][0]), 32'(0));
      check_eq("rst_ack1", 32'(ack[d][1]), 32'(0));
      check_eq("rst_rdata0", 32'(rdata[d][0]), 32'(0));
      check_eq("rst_rdata1", 32'(rdata[d][1]), 32'(0));
      check_eq("rst_mem_en", 32'(mem_en[d]), 32'(0));
      check_eq("rst_mem_we", 32'(mem_we[d]), 32'(0));
      check_eq("rst_mem_addr", 32'(mem_addr[d]), 32'(0));
      check_eq("rst_mem_wdata", 32'(mem_wdata[d]), 32'(0));
      check_eq("rst_busy", 32'(busy[d]), 32'(0));
      check_eq("rst_gnt_id", 32'(gnt[d]), 32'(0));
      check_eq("rst_state", 32'(dbg_state[d]), 32'(0));
    end
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) check_eq("idle_no_mem_en", 32'(en_cnt[d]), 32'(0));

    // Single write then read on port 0.
    access(0, 0, 1'b1, 8'h12, 16'hBEEF, 1);
    access(0, 0, 1'b0, 8'h12, 16'h0000, 1);

    // Contention with both requests held: port 0 first (first tie), then the
    // ACK mask alternates the grants on both instances, one ACK every 3 cycles.
    reset_pulse();
    for (int d = 0; d < 2; d++) begin
      ack_port_log[d].delete();
      ack_cyc_log[d].delete();
    end
    fork
      begin for (int i = 0; i < 3; i++) access(0, 0, 1'b0, 8'h01, 16'h0, 0); end
      begin for (int i = 0; i < 3; i++) access(0, 1, 1'b0, 8'h02, 16'h0, 0); end
      begin for (int i = 0; i < 3; i++) access(1, 0, 1'b0, 8'h01, 16'h0, 0); end
      begin for (int i = 0; i < 3; i++) access(1, 1, 1'b0, 8'h02, 16'h0, 0); end
    join
    for (int d = 0; d < 2; d++) begin
      check_eq("cont_ack_count", 32'(ack_port_log[d].size()), 32'(6));
      for (int i = 0; i < ack_port_log[d].size(); i++) begin
        check_eq("cont_order", 32'(ack_port_log[d][i]), 32'(i % 2));
        if (i > 0)
          check_eq("cont_spacing", 32'(ack_cyc_log[d][i] - ack_cyc_log[d][i-1]), 32'(3));
      end
    end

    // Tie after a solo port 0 access: round-robin favours port 1,
    // fixed priority favours port 0.
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        ack_port_log[d].delete();
        ack_cyc_log[d].delete();
        access(d, 0, 1'b0, 8'h10, 16'h0, 0);
        repeat (2) @(negedge clk);
        fork
          access(d, 0, 1'b0, 8'h20, 16'h0, 0);
          access(d, 1, 1'b0, 8'h21, 16'h0, 0);
        join
        check_eq("tie_ack_count", 32'(ack_port_log[d].size()), 32'(3));
        if (ack_port_log[d].size() >= 2)
          check_eq("tie_winner", 32'(ack_port_log[d][1]), (d == 0) ? 32'(1) : 32'(0));
      end
    end

    // Reset during the ACC cycle of a port 1 read on instance 0.
    access(0, 1, 1'b0, 8'h03, 16'h0, 0);
    tx_cnt[0]++;
    req[0][1] = 1'b1;
    we[0][1] = 1'b0;
    addr[0][1] = 8'h05;
    @(negedge clk);
    check_eq("abort_in_acc_mem_en", 32'(mem_en[0]), 32'(1));
    check_eq("abort_in_acc_busy", 32'(busy[0]), 32'(1));
    rst = 1'b1;
    req[0][1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_ack1", 32'(ack[0][1]), 32'(0));
    check_eq("abort_rdata1", 32'(rdata[0][1]), 32'(0));
    check_eq("abort_state", 32'(dbg_state[0]), 32'(0));
    check_eq("abort_busy", 32'(busy[0]), 32'(0));
    check_eq("abort_mem_en", 32'(mem_en[0]), 32'(0));
    repeat (4) @(negedge clk);
    access(0, 1, 1'b0, 8'h05, 16'h0, 1);

    // Randomised traffic; port 0 uses even addresses, port 1 odd.
    fork
      rand_port(0, 0, 25);
      rand_port(0, 1, 25);
      rand_port(1, 0, 25);
      rand_port(1, 1, 25);
    join
    repeat (5) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      check_eq("mem_en_per_txn", 32'(en_cnt[d]), 32'(tx_cnt[d]));
      for (int p = 0; p < 2; p++)
        check_eq("queue_drained", 32'(exp_q[d*2+p].size()), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
